// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: sequential fetch, in-order response queue, redirect flush.
module instr_fetch_queue #(
    parameter int OPD_WIDTH = 32,
    parameter int PC_WIDTH  = 12,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect,
    input  logic [PC_WIDTH-1:0]  redirect_pc,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic                 imem_rsp_valid,
    input  logic [OPD_WIDTH-1:0] imem_rsp_data,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [OPD_WIDTH-1:0] instr_out,
    output logic [OPD_WIDTH-1:0] instr_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = $clog2(2 * DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [PC_WIDTH-1:0]  fetch_addr;
    logic [PC_WIDTH-1:0]  rsp_pc;
    logic [CW-1:0]        count;
    logic [CW-1:0]        outst;
    logic [DW-1:0]        discard;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [OPD_WIDTH-1:0] data_mem [DEPTH];
    logic [PC_WIDTH-1:0]  pc_mem   [DEPTH];

    logic [CW:0] in_use;
    logic        has_slot;
    logic        issue;
    logic        drop;
    logic        push;
    logic        pop;

    // Queue slots are reserved at issue time, so a response always fits.
    assign in_use   = {1'b0, count} + {1'b0, outst};
    assign has_slot = in_use < (CW + 1)'(DEPTH);

    assign imem_req_valid = !rst && !redirect && has_slot;
    assign imem_addr      = fetch_addr;
    assign issue          = imem_req_valid && imem_req_ready;

    assign drop = !redirect && imem_rsp_valid && (discard != '0);
    assign push = !redirect && imem_rsp_valid && (discard == '0);
    assign pop  = !redirect && instr_valid && instr_ready;

    assign instr_valid = (count != '0);
    assign instr_out   = instr_valid ? data_mem[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? OPD_WIDTH'(pc_mem[rd_ptr]) : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_rsp_data;
            pc_mem[wr_ptr]   <= rsp_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_addr <= '0;
            rsp_pc     <= '0;
            count      <= '0;
            outst      <= '0;
            discard    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else if (redirect) begin
            // Everything in flight becomes stale; one of them may land right now.
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            discard    <= discard + DW'(outst) - DW'(imem_rsp_valid);
            outst      <= '0;
            fetch_addr <= redirect_pc;
            rsp_pc     <= redirect_pc;
        end else begin
            outst   <= outst + CW'(issue) - CW'(push);
            discard <= discard - DW'(drop);
            count   <= count + CW'(push) - CW'(pop);
            if (issue) begin
                fetch_addr <= fetch_addr + PC_WIDTH'(4);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                rsp_pc <= rsp_pc + PC_WIDTH'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with an in-order 1-cycle memory model.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [11:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [11:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [11:0] pend [$];
    logic [11:0] ma;
    int          acc_cnt = 0;
    logic        stall = 1'b0;

    instr_fetch_queue #(
        .OPD_WIDTH(32),
        .PC_WIDTH (12),
        .DEPTH    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [11:0] a);
        return {16'hC0DE, 4'h0, a};
    endfunction

    // Memory: record accepts at negedge, answer in order one cycle later.
    always @(negedge clk) begin
        if (rst) begin
            pend.delete();
            acc_cnt = 0;
        end else if (imem_req_valid && imem_req_ready) begin
            pend.push_back(imem_addr);
            acc_cnt++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst && !stall && pend.size() != 0) begin
            ma = pend.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word(ma);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!instr_valid && n < 12) begin
            tick();
            n++;
        end
        check(tag, 32'(instr_valid), 32'd1);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_req_valid", 32'(imem_req_valid), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_instr_valid", 32'(instr_valid), 0);
        check("rst_instr_out", instr_out, 0);
        check("rst_instr_pc", instr_pc, 0);

        // Streaming at full rate
        rst = 1'b0;
        tick();
        check("t1_addr", 32'(imem_addr), 32'h4);
        check("t1_empty", 32'(instr_valid), 0);
        for (int k = 2; k < 8; k++) begin
            tick();
            check("t1_valid", 32'(instr_valid), 1);
            check("t1_pc", instr_pc, 32'(4 * (k - 2)));
            check("t1_out", instr_out, word(12'(4 * (k - 2))));
        end

        // Decode stalled: queue fills with exactly DEPTH requests
        instr_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 10; k++) tick();
        check("t2_acc_cnt", 32'(acc_cnt), 4);
        check("t2_req_stop", 32'(imem_req_valid), 0);
        instr_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            check("t2_drain_pc", instr_pc, 32'(4 * j));
            check("t2_drain_out", instr_out, word(12'(4 * j)));
            if (j == 1) begin
                check("t2_resume_valid", 32'(imem_req_valid), 1);
                check("t2_resume_addr", 32'(imem_addr), 32'h10);
            end
            tick();
        end

        // Two late responses dropped after redirect
        stall = 1'b1;
        do_reset();
        tick();
        tick();
        imem_req_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 12'h100;
        #1;
        check("t3_no_issue", 32'(imem_req_valid), 0);
        tick();
        redirect = 1'b0;
        imem_req_ready = 1'b1;
        stall = 1'b0;
        check("t3_flushed", 32'(instr_valid), 0);
        wait_valid("t3_timeout");
        check("t3_pc", instr_pc, 32'h100);
        check("t3_out", instr_out, word(12'h100));

        // Redirect during a response, then a second redirect
        do_reset();
        tick();
        tick();
        tick();
        redirect = 1'b1;
        redirect_pc = 12'h100;
        tick();
        redirect_pc = 12'h200;
        check("t4_empty_a", 32'(instr_valid), 0);
        tick();
        redirect = 1'b0;
        check("t4_empty_b", 32'(instr_valid), 0);
        wait_valid("t4_timeout");
        check("t4_pc", instr_pc, 32'h200);
        check("t4_out", instr_out, word(12'h200));

        // Address wrap at the top of the PC space
        redirect = 1'b1;
        redirect_pc = 12'hFF8;
        tick();
        redirect = 1'b0;
        wait_valid("t5_timeout");
        check("t5_pc0", instr_pc, 32'hFF8);
        tick();
        check("t5_pc1", instr_pc, 32'hFFC);
        tick();
        check("t5_pc2", instr_pc, 32'h000);
        check("t5_out2", instr_out, word(12'h000));
        tick();
        check("t5_pc3", instr_pc, 32'h004);

        // Asynchronous reset with a full queue
        instr_ready = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("t6_full_valid", 32'(instr_valid), 1);
        check("t6_full_noreq", 32'(imem_req_valid), 0);
        #1;
        rst = 1'b1;
        #1;
        check("t6_async_valid", 32'(instr_valid), 0);
        check("t6_async_out", instr_out, 0);
        check("t6_async_pc", instr_pc, 0);
        check("t6_async_addr", 32'(imem_addr), 0);
        tick();
        rst = 1'b0;
        instr_ready = 1'b1;
        #1;
        check("t6_restart_valid", 32'(imem_req_valid), 1);
        check("t6_restart_addr", 32'(imem_addr), 0);
        wait_valid("t6_timeout");
        check("t6_first_pc", instr_pc, 0);
        check("t6_first_out", instr_out, word(12'h000));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
